// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants: response codes and routing FSM state encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

endpackage

// File: rtl/axi_lite_addr_dec.sv
// Base/mask address decoder: one-hot select of the lowest-index matching slave,
// miss when no slave window contains the address.
module axi_lite_addr_dec #(
  parameter int                        N_SLV    = 3,
  parameter int                        ADDR_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {32'h02000000, 32'ha0000000, 32'h80000000},
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {32'hffff0000, 32'hfffff000, 32'hf8000000}
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  sel,
  output logic              miss
);

  logic hit;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!hit && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
    miss = !hit;
  end

endmodule

// File: rtl/axi_lite_xbar_n.sv
// 1-master to N-slave AXI4-Lite router with independent read/write FSMs that
// latch the decoded target at address acceptance; unmapped accesses get DECERR.
import axi_lite_pkg::*;

module axi_lite_xbar_n #(
  parameter int                        N_SLV    = 3,
  parameter int                        ADDR_W   = 32,
  parameter int                        DATA_W   = 32,
  parameter int                        STRB_W   = 8,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {32'h02000000, 32'ha0000000, 32'h80000000},
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {32'hffff0000, 32'hfffff000, 32'hf8000000}
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         i_axi_araddr,
  input  logic                      i_axi_arvalid,
  output logic                      o_axi_arready,
  output logic [DATA_W-1:0]         o_axi_rdata,
  output logic [1:0]                o_axi_rresp,
  output logic                      o_axi_rvalid,
  input  logic                      i_axi_rready,
  input  logic [ADDR_W-1:0]         i_axi_awaddr,
  input  logic                      i_axi_awvalid,
  output logic                      o_axi_awready,
  input  logic [DATA_W-1:0]         i_axi_wdata,
  input  logic [STRB_W-1:0]         i_axi_wstrb,
  input  logic                      i_axi_wvalid,
  output logic                      o_axi_wready,
  output logic [1:0]                o_axi_bresp,
  output logic                      o_axi_bvalid,
  input  logic                      i_axi_bready,
  output logic [N_SLV*ADDR_W-1:0]   o_axi_s_araddr,
  output logic [N_SLV-1:0]          o_axi_s_arvalid,
  input  logic [N_SLV-1:0]          i_axi_s_arready,
  input  logic [N_SLV*DATA_W-1:0]   i_axi_s_rdata,
  input  logic [N_SLV*2-1:0]        i_axi_s_rresp,
  input  logic [N_SLV-1:0]          i_axi_s_rvalid,
  output logic [N_SLV-1:0]          o_axi_s_rready,
  output logic [N_SLV*ADDR_W-1:0]   o_axi_s_awaddr,
  output logic [N_SLV-1:0]          o_axi_s_awvalid,
  input  logic [N_SLV-1:0]          i_axi_s_awready,
  output logic [N_SLV*DATA_W-1:0]   o_axi_s_wdata,
  output logic [N_SLV*STRB_W-1:0]   o_axi_s_wstrb,
  output logic [N_SLV-1:0]          o_axi_s_wvalid,
  input  logic [N_SLV-1:0]          i_axi_s_wready,
  input  logic [N_SLV*2-1:0]        i_axi_s_bresp,
  input  logic [N_SLV-1:0]          i_axi_s_bvalid,
  output logic [N_SLV-1:0]          o_axi_s_bready,
  output logic [1:0]                o_dbg_r_state,
  output logic [1:0]                o_dbg_w_state
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both 1; valid never waits on ready, and a raised valid holds until accepted.

  logic [N_SLV-1:0]  ar_sel, aw_sel;
  logic              ar_miss, aw_miss;

  logic [1:0]        r_state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [N_SLV-1:0]  r_sel_q;
  logic              r_err_q;

  logic [1:0]        w_state_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [N_SLV-1:0]  w_sel_q;
  logic              w_err_q;
  logic              aw_done_q, w_done_q;
  logic              aw_rdy, w_rdy, aw_done_n, w_done_n;

  axi_lite_addr_dec #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_ar_dec (.addr(i_axi_araddr), .sel(ar_sel), .miss(ar_miss));

  axi_lite_addr_dec #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_aw_dec (.addr(i_axi_awaddr), .sel(aw_sel), .miss(aw_miss));

  assign o_dbg_r_state = r_state_q;
  assign o_dbg_w_state = w_state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      r_sel_q   <= '0;
      r_err_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: if (i_axi_arvalid) begin
          araddr_q  <= i_axi_araddr;
          r_sel_q   <= ar_sel;
          r_err_q   <= ar_miss;
          r_state_q <= R_ADDR;
        end
        R_ADDR: if (o_axi_arready) r_state_q <= R_DATA;
        R_DATA: if (o_axi_rvalid && i_axi_rready) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // r_sel_q is all-zero for the error target, so slave-side gating needs no r_err_q term.
  always_comb begin
    o_axi_s_arvalid = '0;
    o_axi_s_araddr  = '0;
    o_axi_s_rready  = '0;
    o_axi_arready   = 1'b0;
    o_axi_rvalid    = 1'b0;
    o_axi_rdata     = '0;
    o_axi_rresp     = RESP_OKAY;
    case (r_state_q)
      R_ADDR: begin
        o_axi_arready   = r_err_q | (|(i_axi_s_arready & r_sel_q));
        o_axi_s_arvalid = r_sel_q;
        for (int i = 0; i < N_SLV; i++)
          if (r_sel_q[i]) o_axi_s_araddr[i*ADDR_W +: ADDR_W] = araddr_q;
      end
      R_DATA: begin
        if (r_err_q) begin
          o_axi_rvalid = 1'b1;
          o_axi_rresp  = RESP_DECERR;
        end else begin
          o_axi_rvalid   = |(i_axi_s_rvalid & r_sel_q);
          o_axi_s_rready = r_sel_q & {N_SLV{i_axi_rready}};
          for (int i = 0; i < N_SLV; i++)
            if (r_sel_q[i]) begin
              o_axi_rdata = i_axi_s_rdata[i*DATA_W +: DATA_W];
              o_axi_rresp = i_axi_s_rresp[i*2 +: 2];
            end
        end
      end
      default: ;
    endcase
  end

  assign aw_rdy    = w_err_q | (|(i_axi_s_awready & w_sel_q));
  assign w_rdy     = w_err_q | (|(i_axi_s_wready & w_sel_q));
  assign aw_done_n = aw_done_q | o_axi_awready;
  assign w_done_n  = w_done_q | (o_axi_wready & i_axi_wvalid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      w_sel_q   <= '0;
      w_err_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (i_axi_awvalid) begin
          awaddr_q  <= i_axi_awaddr;
          w_sel_q   <= aw_sel;
          w_err_q   <= aw_miss;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          w_state_q <= W_ADDR;
        end
        W_ADDR: begin
          if (aw_done_n && w_done_n) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_state_q <= W_RESP;
          end else begin
            aw_done_q <= aw_done_n;
            w_done_q  <= w_done_n;
          end
        end
        W_RESP: if (o_axi_bvalid && i_axi_bready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // AW is replayed from the latched address; W is forwarded live from the master.
  always_comb begin
    o_axi_s_awvalid = '0;
    o_axi_s_awaddr  = '0;
    o_axi_s_wvalid  = '0;
    o_axi_s_wdata   = '0;
    o_axi_s_wstrb   = '0;
    o_axi_s_bready  = '0;
    o_axi_awready   = 1'b0;
    o_axi_wready    = 1'b0;
    o_axi_bvalid    = 1'b0;
    o_axi_bresp     = RESP_OKAY;
    case (w_state_q)
      W_ADDR: begin
        o_axi_awready = !aw_done_q && aw_rdy;
        o_axi_wready  = !w_done_q && w_rdy;
        if (!aw_done_q) o_axi_s_awvalid = w_sel_q;
        if (!w_done_q && i_axi_wvalid) o_axi_s_wvalid = w_sel_q;
        for (int i = 0; i < N_SLV; i++)
          if (w_sel_q[i]) begin
            if (!aw_done_q) o_axi_s_awaddr[i*ADDR_W +: ADDR_W] = awaddr_q;
            if (!w_done_q) begin
              o_axi_s_wdata[i*DATA_W +: DATA_W] = i_axi_wdata;
              o_axi_s_wstrb[i*STRB_W +: STRB_W] = i_axi_wstrb;
            end
          end
      end
      W_RESP: begin
        if (w_err_q) begin
          o_axi_bvalid = 1'b1;
          o_axi_bresp  = RESP_DECERR;
        end else begin
          o_axi_bvalid   = |(i_axi_s_bvalid & w_sel_q);
          o_axi_s_bready = w_sel_q & {N_SLV{i_axi_bready}};
          for (int i = 0; i < N_SLV; i++)
            if (w_sel_q[i]) o_axi_bresp = i_axi_s_bresp[i*2 +: 2];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_xbar_n.sv
// Directed bench for axi_lite_xbar_n: bench-side slave models, expected-value queue.
import axi_lite_pkg::*;

module tb_axi_lite_xbar_n;

  localparam int NS = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [31:0]    araddr = '0, awaddr = '0, wdata = '0;
  logic           arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [7:0]     wstrb = '0;
  logic           o_axi_arready, o_axi_rvalid, o_axi_awready, o_axi_wready, o_axi_bvalid;
  logic [31:0]    o_axi_rdata;
  logic [1:0]     o_axi_rresp, o_axi_bresp, dbg_r, dbg_w;
  logic [NS*32-1:0] o_axi_s_araddr, o_axi_s_awaddr, o_axi_s_wdata;
  logic [NS*8-1:0]  o_axi_s_wstrb;
  logic [NS-1:0]  o_axi_s_arvalid, o_axi_s_rready, o_axi_s_awvalid, o_axi_s_wvalid, o_axi_s_bready;
  logic [NS-1:0]  s_arready = '0, s_rvalid = '0, s_awready = '0, s_wready = '0, s_bvalid = '0;
  logic [NS*32-1:0] s_rdata = '0;
  logic [NS*2-1:0]  s_rresp = '0, s_bresp = '0;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int cnt_ar[NS], cnt_aw[NS], cnt_w[NS];
  int snap_ar[NS], snap_aw[NS], snap_w[NS];

  axi_lite_xbar_n dut (
    .clock(clock), .reset(reset),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(o_axi_arready),
    .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp), .o_axi_rvalid(o_axi_rvalid),
    .i_axi_rready(rready),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(o_axi_awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(o_axi_wready),
    .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid), .i_axi_bready(bready),
    .o_axi_s_araddr(o_axi_s_araddr), .o_axi_s_arvalid(o_axi_s_arvalid), .i_axi_s_arready(s_arready),
    .i_axi_s_rdata(s_rdata), .i_axi_s_rresp(s_rresp), .i_axi_s_rvalid(s_rvalid),
    .o_axi_s_rready(o_axi_s_rready),
    .o_axi_s_awaddr(o_axi_s_awaddr), .o_axi_s_awvalid(o_axi_s_awvalid), .i_axi_s_awready(s_awready),
    .o_axi_s_wdata(o_axi_s_wdata), .o_axi_s_wstrb(o_axi_s_wstrb), .o_axi_s_wvalid(o_axi_s_wvalid),
    .i_axi_s_wready(s_wready),
    .i_axi_s_bresp(s_bresp), .i_axi_s_bvalid(s_bvalid), .o_axi_s_bready(o_axi_s_bready),
    .o_dbg_r_state(dbg_r), .o_dbg_w_state(dbg_w)
  );

  wire any_out = |{o_axi_arready, o_axi_rdata, o_axi_rresp, o_axi_rvalid, o_axi_awready,
                   o_axi_wready, o_axi_bresp, o_axi_bvalid, o_axi_s_araddr, o_axi_s_arvalid,
                   o_axi_s_rready, o_axi_s_awaddr, o_axi_s_awvalid, o_axi_s_wdata,
                   o_axi_s_wstrb, o_axi_s_wvalid, o_axi_s_bready};

  initial for (int i = 0; i < NS; i++) begin cnt_ar[i] = 0; cnt_aw[i] = 0; cnt_w[i] = 0; end

  always @(negedge clock)
    for (int i = 0; i < NS; i++) begin
      if (o_axi_s_arvalid[i]) cnt_ar[i] <= cnt_ar[i] + 1;
      if (o_axi_s_awvalid[i]) cnt_aw[i] <= cnt_aw[i] + 1;
      if (o_axi_s_wvalid[i])  cnt_w[i]  <= cnt_w[i] + 1;
    end

  task automatic snapshot();
    @(posedge clock); #1;
    for (int i = 0; i < NS; i++) begin snap_ar[i] = cnt_ar[i]; snap_aw[i] = cnt_aw[i]; snap_w[i] = cnt_w[i]; end
  endtask

  function automatic logic [NS-1:0] ar_mask();
    for (int i = 0; i < NS; i++) ar_mask[i] = (cnt_ar[i] != snap_ar[i]);
  endfunction
  function automatic logic [NS-1:0] aw_mask();
    for (int i = 0; i < NS; i++) aw_mask[i] = (cnt_aw[i] != snap_aw[i]) || (cnt_w[i] != snap_w[i]);
  endfunction

  task automatic timeout(input string name, input bit expired);
    checks++;
    if (expired) begin errors++; $display("FAIL %s: timeout waiting on handshake", name); end
  endtask

  // ---------------- driver tasks ----------------
  task automatic master_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(posedge clock); #1; araddr = addr; arvalid = 1;
    do begin @(negedge clock); n++; end while (!o_axi_arready && n < 50);
    timeout("master_ar", !o_axi_arready);
    @(posedge clock); #1; arvalid = 0; rready = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!o_axi_rvalid && n < 50);
    timeout("master_r", !o_axi_rvalid);
    d = o_axi_rdata; r = o_axi_rresp;
    @(posedge clock); #1; rready = 0;
  endtask

  task automatic slave_read(input int idx, input logic [31:0] d, input logic [1:0] r, input int dly);
    int n = 0;
    do begin @(negedge clock); n++; end while (!o_axi_s_arvalid[idx] && n < 50);
    timeout("slave_ar", !o_axi_s_arvalid[idx]);
    repeat (dly) @(posedge clock);
    @(posedge clock); #1; s_arready[idx] = 1;
    @(posedge clock); #1; s_arready[idx] = 0; s_rvalid[idx] = 1;
    s_rdata[idx*32 +: 32] = d; s_rresp[idx*2 +: 2] = r;
    n = 0;
    do begin @(negedge clock); n++; end while (!o_axi_s_rready[idx] && n < 50);
    timeout("slave_r", !o_axi_s_rready[idx]);
    @(posedge clock); #1; s_rvalid[idx] = 0; s_rdata[idx*32 +: 32] = '0; s_rresp[idx*2 +: 2] = '0;
  endtask

  task automatic master_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                              input bit w_lead, output logic [1:0] r);
    bit aw_p = 1, w_p = 1, hs_a, hs_w;
    int n = 0;
    @(posedge clock); #1; wdata = d; wstrb = s; wvalid = 1;
    if (w_lead) begin @(posedge clock); #1; end
    awaddr = a; awvalid = 1;
    while ((aw_p || w_p) && n < 50) begin
      @(negedge clock); n++;
      hs_a = aw_p && o_axi_awready; hs_w = w_p && o_axi_wready;
      @(posedge clock); #1;
      if (hs_a) begin awvalid = 0; aw_p = 0; end
      if (hs_w) begin wvalid = 0; w_p = 0; end
    end
    timeout("master_aw_w", aw_p || w_p);
    awvalid = 0; wvalid = 0; bready = 1; n = 0;
    do begin @(negedge clock); n++; end while (!o_axi_bvalid && n < 50);
    timeout("master_b", !o_axi_bvalid);
    r = o_axi_bresp;
    @(posedge clock); #1; bready = 0;
  endtask

  task automatic slave_write(input int idx, input logic [1:0] r,
                             output logic [31:0] a, output logic [31:0] d, output logic [7:0] s);
    bit ga = 0, gw = 0;
    int n = 0;
    a = '0; d = '0; s = '0;
    @(posedge clock); #1; s_awready[idx] = 1; s_wready[idx] = 1;
    while (!(ga && gw) && n < 60) begin
      @(negedge clock); n++;
      if (o_axi_s_awvalid[idx] && !ga) begin a = o_axi_s_awaddr[idx*32 +: 32]; ga = 1; end
      if (o_axi_s_wvalid[idx] && !gw) begin d = o_axi_s_wdata[idx*32 +: 32]; s = o_axi_s_wstrb[idx*8 +: 8]; gw = 1; end
    end
    timeout("slave_aw_w", !(ga && gw));
    @(posedge clock); #1; s_awready[idx] = 0; s_wready[idx] = 0;
    s_bvalid[idx] = 1; s_bresp[idx*2 +: 2] = r; n = 0;
    do begin @(negedge clock); n++; end while (!o_axi_s_bready[idx] && n < 50);
    timeout("slave_b", !o_axi_s_bready[idx]);
    @(posedge clock); #1; s_bvalid[idx] = 0; s_bresp[idx*2 +: 2] = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clock);
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL reset_outputs: got nonzero output, want all 0"); end
    checks++; if (dbg_r !== R_IDLE || dbg_w !== W_IDLE) begin errors++; $display("FAIL reset_state: got r=%0d w=%0d, want 0/0", dbg_r, dbg_w); end
    @(posedge clock); #1; reset = 1;
  endtask

  task automatic test_read_slave0();
    logic [31:0] d, e; logic [1:0] r;
    snapshot();
    exp_q.push_back(32'hdeadbeef); exp_q.push_back({30'd0, RESP_OKAY});
    fork
      slave_read(0, 32'hdeadbeef, RESP_OKAY, 2);
      master_read(32'h80000010, d, r);
    join
    e = exp_q.pop_front(); checks++; if (d !== e) begin errors++; $display("FAIL rd0_data: got %h want %h", d, e); end
    e = exp_q.pop_front(); checks++; if (r !== e[1:0]) begin errors++; $display("FAIL rd0_resp: got %b want %b", r, e[1:0]); end
    checks++; if (ar_mask() !== 3'b001) begin errors++; $display("FAIL rd0_route: got %b want 001", ar_mask()); end
  endtask

  task automatic test_read_clint();
    logic [31:0] d, e; logic [1:0] r;
    snapshot();
    exp_q.push_back(32'h12345678);
    fork
      slave_read(2, 32'h12345678, RESP_OKAY, 0);
      master_read(32'h02000000, d, r);
    join
    e = exp_q.pop_front(); checks++; if (d !== e || r !== RESP_OKAY) begin errors++; $display("FAIL rd2_data: got %h/%b want %h/00", d, r, e); end
    checks++; if (ar_mask() !== 3'b100) begin errors++; $display("FAIL rd2_route: got %b want 100", ar_mask()); end
  endtask

  task automatic test_write_uart();
    logic [31:0] a, d, e; logic [7:0] s; logic [1:0] r;
    snapshot();
    exp_q.push_back(32'ha00003f8); exp_q.push_back(32'h41); exp_q.push_back(32'h01); exp_q.push_back({30'd0, RESP_OKAY});
    fork
      slave_write(1, RESP_OKAY, a, d, s);
      master_write(32'ha00003f8, 32'h41, 8'h01, 1'b1, r);
    join
    e = exp_q.pop_front(); checks++; if (a !== e) begin errors++; $display("FAIL wr_awaddr: got %h want %h", a, e); end
    e = exp_q.pop_front(); checks++; if (d !== e) begin errors++; $display("FAIL wr_wdata: got %h want %h", d, e); end
    e = exp_q.pop_front(); checks++; if (s !== e[7:0]) begin errors++; $display("FAIL wr_wstrb: got %h want %h", s, e[7:0]); end
    e = exp_q.pop_front(); checks++; if (r !== e[1:0]) begin errors++; $display("FAIL wr_bresp: got %b want %b", r, e[1:0]); end
    checks++; if (aw_mask() !== 3'b010) begin errors++; $display("FAIL wr_route: got %b want 010", aw_mask()); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d, e; logic [1:0] r, br;
    snapshot();
    exp_q.push_back(32'h0); exp_q.push_back({30'd0, RESP_DECERR}); exp_q.push_back({30'd0, RESP_DECERR});
    fork
      master_read(32'h10000000, d, r);
      master_write(32'h10000000, 32'h55aa55aa, 8'hff, 1'b0, br);
    join
    e = exp_q.pop_front(); checks++; if (d !== e) begin errors++; $display("FAIL err_rdata: got %h want %h", d, e); end
    e = exp_q.pop_front(); checks++; if (r !== e[1:0]) begin errors++; $display("FAIL err_rresp: got %b want %b", r, e[1:0]); end
    e = exp_q.pop_front(); checks++; if (br !== e[1:0]) begin errors++; $display("FAIL err_bresp: got %b want %b", br, e[1:0]); end
    checks++; if (ar_mask() !== 3'b000 || aw_mask() !== 3'b000) begin errors++; $display("FAIL err_route: got ar=%b aw=%b want 000/000", ar_mask(), aw_mask()); end
  endtask

  task automatic test_hold_rready();
    logic [31:0] e; int n = 0;
    snapshot();
    exp_q.push_back(32'h5a5a1234);
    fork
      slave_read(0, 32'h5a5a1234, RESP_OKAY, 0);
      begin
        @(posedge clock); #1; araddr = 32'h80000040; arvalid = 1;
        do begin @(negedge clock); n++; end while (!o_axi_arready && n < 50);
        timeout("hold_ar", !o_axi_arready);
        @(posedge clock); #1; arvalid = 0; araddr = 32'h02000000;
        n = 0;
        do begin @(negedge clock); n++; end while (!o_axi_rvalid && n < 50);
        timeout("hold_rvalid", !o_axi_rvalid);
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (o_axi_rvalid !== 1'b1 || o_axi_rdata !== e || o_axi_s_rready !== 3'b000) begin
            errors++; $display("FAIL hold_stable[%0d]: got v=%b d=%h rr=%b want 1/%h/000", k, o_axi_rvalid, o_axi_rdata, o_axi_s_rready, e);
          end
          araddr = 32'h02000000 + k;
          @(negedge clock);
        end
        @(posedge clock); #1; rready = 1;
        @(negedge clock);
        checks++; if (o_axi_s_rready !== 3'b001 || o_axi_rdata !== e) begin errors++; $display("FAIL hold_release: got rr=%b d=%h want 001/%h", o_axi_s_rready, o_axi_rdata, e); end
        @(posedge clock); #1; rready = 0;
      end
    join
    checks++; if (ar_mask() !== 3'b001) begin errors++; $display("FAIL hold_route: got %b want 001", ar_mask()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e, v; logic [1:0] r; int idx;
    for (int t = 0; t < 4; t++) begin
      idx = (t % 2 == 0) ? 0 : 2;
      v = $urandom;
      exp_q.push_back(v);
      fork
        slave_read(idx, v, RESP_OKAY, $urandom_range(0, 3));
        master_read((idx == 0) ? 32'h80001000 + t * 4 : 32'h0200bff8, d, r);
      join
      e = exp_q.pop_front();
      checks++; if (d !== e || r !== RESP_OKAY) begin errors++; $display("FAIL b2b[%0d]: got %h/%b want %h/00", t, d, r, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e; logic [1:0] r; int n = 0;
    @(posedge clock); #1; araddr = 32'h80000000; arvalid = 1; s_arready[0] = 1;
    awaddr = 32'ha0000000; awvalid = 1;
    do begin @(negedge clock); n++; end while ((dbg_r !== R_DATA || dbg_w !== W_ADDR) && n < 20);
    timeout("mid_states", dbg_r !== R_DATA || dbg_w !== W_ADDR);
    s_arready = '0; s_rvalid[0] = 1; s_rdata[31:0] = 32'hcafef00d;
    #1;
    checks++; if (o_axi_rvalid !== 1'b1) begin errors++; $display("FAIL mid_busy: got rvalid=%b want 1", o_axi_rvalid); end
    reset = 0; #1;
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got nonzero output, want all 0"); end
    checks++; if (dbg_r !== R_IDLE || dbg_w !== W_IDLE) begin errors++; $display("FAIL mid_reset_state: got r=%0d w=%0d want 0/0", dbg_r, dbg_w); end
    arvalid = 0; awvalid = 0; s_rvalid = '0; s_rdata = '0;
    @(posedge clock); #1; reset = 1;
    exp_q.push_back(32'h0badc0de);
    fork
      slave_read(0, 32'h0badc0de, RESP_OKAY, 1);
      master_read(32'h80000000, d, r);
    join
    e = exp_q.pop_front();
    checks++; if (d !== e || r !== RESP_OKAY) begin errors++; $display("FAIL post_reset_read: got %h/%b want %h/00", d, r, e); end
  endtask

  initial begin
    test_reset();
    test_read_slave0();
    test_read_clint();
    test_write_uart();
    test_unmapped();
    test_hold_rready();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_xbar_n.md
Name: axi_lite_xbar_n

Overview:
- Parametrised 1-master to N-slave AXI4-Lite router. It replaces the fixed combinational SRAM/UART/CLINT decoder.
- Independent read and write routing FSMs latch the decoded target when the address is accepted and hold it until the response completes, so a slave never sees a mid-transaction address change.
- Unmapped addresses are answered internally with DECERR.
- Sits between the core's LSU/IFU arbiter and the memory/peripheral slaves.

Parameters:
- N_SLV, 3, number of slave ports, 1..8.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STRB_W, 8, write-strobe width, kept at 8 for core compatibility.
- SLV_BASE, {32'h02000000,32'ha0000000,32'h80000000}, flattened N_SLV*ADDR_W base addresses; slave i occupies slice i.
- SLV_MASK, {32'hffff0000,32'hfffff000,32'hf8000000}, flattened masks; slave i hits when (addr & MASK_i) == BASE_i.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_axi_araddr/arvalid  in  ADDR_W/1;  o_axi_arready  out  1
- o_axi_rdata/rresp/rvalid  out  DATA_W/2/1;  i_axi_rready  in  1
- i_axi_awaddr/awvalid  in  ADDR_W/1;  o_axi_awready  out  1
- i_axi_wdata/wstrb/wvalid  in  DATA_W/STRB_W/1;  o_axi_wready  out  1
- o_axi_bresp/bvalid  out  2/1;  i_axi_bready  in  1
- o_axi_s_araddr  out  N_SLV*ADDR_W;  o_axi_s_arvalid  out  N_SLV;  i_axi_s_arready  in  N_SLV
- i_axi_s_rdata  in  N_SLV*DATA_W;  i_axi_s_rresp  in  N_SLV*2;  i_axi_s_rvalid  in  N_SLV;  o_axi_s_rready  out  N_SLV
- o_axi_s_awaddr  out  N_SLV*ADDR_W;  o_axi_s_awvalid  out  N_SLV;  i_axi_s_awready  in  N_SLV
- o_axi_s_wdata  out  N_SLV*DATA_W;  o_axi_s_wstrb  out  N_SLV*STRB_W;  o_axi_s_wvalid  out  N_SLV;  i_axi_s_wready  in  N_SLV
- i_axi_s_bresp  in  N_SLV*2;  i_axi_s_bvalid  in  N_SLV;  o_axi_s_bready  out  N_SLV

Behaviour:
- Reset (reset low, asynchronous): both FSMs go to IDLE. All valid and ready outputs are 0; all data, resp and address outputs are 0.
- Decode: combinational on the master address. The lowest-index matching slave wins. No match selects the internal error target.
- Read FSM, R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: o_axi_arready=0. On i_axi_arvalid, register araddr and the target, then go to R_ADDR. This adds one cycle of AR latency.
  - R_ADDR: drive the registered araddr and arvalid only to the target; the master's o_axi_arready mirrors the target's arready. Advance when the target's arready=1.
  - Error target in R_ADDR: arready is internal and 1 for one cycle.
  - R_DATA: forward the target's rdata/rresp/rvalid and route i_axi_rready back to it. On rvalid&rready, return to R_IDLE.
  - Error target in R_DATA: rvalid=1, rdata=0, rresp=2'b11, held until rready.
- Write FSM, W_IDLE -> W_ADDR -> W_RESP -> W_IDLE:
  - W_IDLE: latch the target on i_axi_awvalid.
  - W_ADDR: forward aw and w to the target. Track aw_done and w_done flags separately, because the AW and W handshakes may complete in either order or in the same cycle. Each valid is deasserted after its handshake. Advance when both are done.
  - W_RESP: forward bvalid/bresp and route bready. Return to W_IDLE on bvalid&bready.
  - Error target: awready=wready=1 in W_ADDR; bresp=2'b11.
- Non-selected slave ports are held at all-zero.
- Read and write paths are fully independent and may target the same slave concurrently.
- Master inputs that change while the FSM is busy are ignored; the route is the value latched at acceptance.
- There is at most one outstanding transaction per direction. A new arvalid is not accepted until R_IDLE.
- Back-to-back transactions: R_DATA -> R_IDLE -> R_ADDR gives a minimum period of 3 cycles per read.
- Reset asserted mid-transaction aborts it. Slaves are reset on the same signal.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; FSM state encodings for the read and write FSMs.
- One sub-module, axi_lite_addr_dec:
  - Parameterised by N_SLV, SLV_BASE, SLV_MASK.
  - Inputs: addr.
  - Outputs: one-hot sel[N_SLV-1:0] and miss.
  - Instantiated twice, once for AR and once for AW.

Test Plan:
- Read 0x80000010, slave0 returns 0xdeadbeef with arready delayed 2 cycles -> master sees rdata=0xdeadbeef, rresp=00; only s_arvalid[0] ever asserts.
- Read 0x02000000, clint slave2 returns 0x12345678 -> routed to slave 2; s_arvalid[0] and s_arvalid[1] stay 0 throughout.
- Write 0xa00003f8 data 0x41 strb 0x01, with W valid one cycle before AW -> slave1 receives both, one B with bresp=00; slave0 untouched.
- Read and write to unmapped 0x10000000 -> arready/awready/wready handshakes complete; rresp=11 with rdata=0; bresp=11; no s_* valid asserted.
- Hold rready=0 for 5 cycles while slave0 rvalid=1, changing i_axi_araddr to 0x02000000 meanwhile -> route stays on slave0 and data stays stable until rready.
- Assert reset in R_DATA and W_ADDR simultaneously -> all outputs read 0 in the same cycle; after release, a read of 0x80000000 completes normally.
